// File: rtl/thread_fetch_sel_pkg.sv
// Shared types for the multi-thread fetch scheduler: thread ids, per-thread state and context.
// Optional per-thread fetch counters are enabled with THREAD_FETCH_PERF_EN.
package thread_fetch_sel_pkg;

  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned VLEN        = 32;
  localparam int unsigned TID_W       = $clog2(NUM_THREADS);
  localparam int unsigned PERF_W      = 32;

  typedef logic [TID_W-1:0] tid_t;
  typedef logic [VLEN-1:0]  pc_t;

  typedef enum logic [1:0] {
    THR_OFF  = 2'd0,
    THR_RUN  = 2'd1,
    THR_MISS = 2'd2
  } thr_state_e;

  typedef struct packed {
    thr_state_e state;
    pc_t        pc;
  } thr_ctx_t;

  // Next sequential fetch address: align down to the beat, then step one beat (wraps at 2^VLEN).
  function automatic pc_t next_fetch_pc(input pc_t pc, input int unsigned fetch_bytes);
    pc_t step;
    step = pc_t'(fetch_bytes);
    return (pc & ~(step - pc_t'(1))) + step;
  endfunction

endpackage

// File: rtl/thread_fetch_sel_rr_pick.sv
// Rotate-priority picker: grants the first set mask bit after ptr, wrapping around all threads.
module thread_rr_pick
  import thread_fetch_sel_pkg::*;
(
  input  logic [NUM_THREADS-1:0] mask,
  input  tid_t                   ptr,
  output logic [NUM_THREADS-1:0] gnt,
  output tid_t                   tid
);

  logic found;
  tid_t cand;

  always_comb begin
    gnt   = '0;
    tid   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= int'(NUM_THREADS); k++) begin
      cand = tid_t'((int'(ptr) + k) % int'(NUM_THREADS));
      if (!found && mask[cand]) begin
        found = 1'b1;
        tid   = cand;
      end
    end
    if (found) gnt[tid] = 1'b1;
  end

endmodule

// File: rtl/thread_fetch_sel.sv
// Per-thread fetch PC/state tracking plus a single registered round-robin fetch request slot.
// Build option: THREAD_FETCH_PERF_EN adds 32-bit accepted-fetch counters per thread.
module thread_fetch_sel
  import thread_fetch_sel_pkg::*;
#(
  parameter int unsigned FETCH_BYTES = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_THREADS-1:0]      thread_en_i,
  input  logic [VLEN-1:0]             boot_addr_i,
  input  logic                        redirect_valid_i,
  input  logic [TID_W-1:0]            redirect_tid_i,
  input  logic [VLEN-1:0]             redirect_pc_i,
  input  logic                        miss_valid_i,
  input  logic [TID_W-1:0]            miss_tid_i,
  input  logic [VLEN-1:0]             miss_pc_i,
  input  logic                        refill_valid_i,
  input  logic [TID_W-1:0]            refill_tid_i,
  output logic                        fetch_valid_o,
  input  logic                        fetch_ready_i,
  output logic [TID_W-1:0]            fetch_tid_o,
  output logic [VLEN-1:0]             fetch_pc_o,
  output logic [2*NUM_THREADS-1:0]    thread_state_o,
  output logic [PERF_W*NUM_THREADS-1:0] perf_fetch_cnt_o
);

  localparam int unsigned NT = NUM_THREADS;

  thr_ctx_t        ctx_q [NT];
  thr_ctx_t        ctx_d [NT];
  logic [NT-1:0]   redir_hit, miss_hit, refill_hit, acc_hit, eligible;
  logic [NT-1:0]   pick_gnt;
  tid_t            pick_tid;
  logic            pick_found;
  pc_t             pick_pc;
  tid_t            rr_ptr_q;
  logic            accept, kill, load;

  // Fetch handshake: a request transfers on a cycle where fetch_valid_o && fetch_ready_i;
  // while valid && !ready the tid/pc stay put unless the held thread is redirected, misses or
  // is disabled, in which case the slot drops for one cycle and is re-picked.
  assign accept = fetch_valid_o & fetch_ready_i;

  always_comb begin
    for (int i = 0; i < int'(NT); i++) begin
      redir_hit[i]  = redirect_valid_i && (redirect_tid_i == tid_t'(i));
      miss_hit[i]   = miss_valid_i     && (miss_tid_i     == tid_t'(i));
      refill_hit[i] = refill_valid_i   && (refill_tid_i   == tid_t'(i));
      acc_hit[i]    = accept           && (fetch_tid_o    == tid_t'(i));
    end
  end

  // Per-thread FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NT); i++) begin
        ctx_q[i].state <= THR_OFF;
        ctx_q[i].pc    <= boot_addr_i;
      end
    end else begin
      for (int i = 0; i < int'(NT); i++) ctx_q[i] <= ctx_d[i];
    end
  end

  // Per-thread FSM: next state. Disable dominates; redirect beats miss beats accept for the PC.
  always_comb begin
    for (int i = 0; i < int'(NT); i++) begin
      ctx_d[i] = ctx_q[i];
      if (!thread_en_i[i]) begin
        ctx_d[i].state = THR_OFF;
      end else if (ctx_q[i].state == THR_OFF) begin
        ctx_d[i].state = THR_RUN;
        ctx_d[i].pc    = boot_addr_i;
      end else begin
        if (redir_hit[i])     ctx_d[i].pc = redirect_pc_i;
        else if (miss_hit[i]) ctx_d[i].pc = miss_pc_i;
        else if (acc_hit[i])  ctx_d[i].pc = next_fetch_pc(ctx_q[i].pc, FETCH_BYTES);
        if (miss_hit[i] && !redir_hit[i])
          ctx_d[i].state = THR_MISS;
        else if (refill_hit[i] && ctx_q[i].state == THR_MISS)
          ctx_d[i].state = THR_RUN;
      end
    end
  end

  // Per-thread FSM: outputs. Only threads running now and not leaving RUN this cycle may be picked.
  always_comb begin
    for (int i = 0; i < int'(NT); i++) begin
      thread_state_o[2*i +: 2] = ctx_q[i].state;
      eligible[i] = (ctx_q[i].state == THR_RUN) && (ctx_d[i].state == THR_RUN);
    end
  end

  thread_rr_pick u_pick (
    .mask (eligible),
    .ptr  (rr_ptr_q),
    .gnt  (pick_gnt),
    .tid  (pick_tid)
  );

  // The loaded PC comes from next-state context so same-cycle redirect/increment is seen.
  always_comb begin
    pick_pc = '0;
    for (int i = 0; i < int'(NT); i++)
      if (pick_gnt[i]) pick_pc = pick_pc | ctx_d[i].pc;
  end

  assign pick_found = |pick_gnt;
  assign kill = fetch_valid_o & ~fetch_ready_i &
                (redir_hit[fetch_tid_o] | miss_hit[fetch_tid_o] | ~thread_en_i[fetch_tid_o]);
  assign load = ~fetch_valid_o | accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_valid_o <= 1'b0;
      fetch_tid_o   <= '0;
      fetch_pc_o    <= '0;
      rr_ptr_q      <= tid_t'(NT - 1);
    end else if (kill) begin
      fetch_valid_o <= 1'b0;
    end else if (load) begin
      fetch_valid_o <= pick_found;
      if (pick_found) begin
        fetch_tid_o <= pick_tid;
        fetch_pc_o  <= pick_pc;
        rr_ptr_q    <= pick_tid;
      end
    end
  end

`ifdef THREAD_FETCH_PERF_EN
  logic [PERF_W-1:0] perf_cnt_q [NT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NT); i++) perf_cnt_q[i] <= '0;
    end else if (accept) begin
      perf_cnt_q[fetch_tid_o] <= perf_cnt_q[fetch_tid_o] + PERF_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NT); i++) perf_fetch_cnt_o[PERF_W*i +: PERF_W] = perf_cnt_q[i];
  end
`else
  assign perf_fetch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_thread_fetch_sel.sv
// Directed bench for thread_fetch_sel: round-robin order, hold, miss/refill, redirect kill,
// PC wrap and (optionally) per-thread counters, sampled on the falling clock edge.
module tb_thread_fetch_sel;
  import thread_fetch_sel_pkg::*;

  localparam int unsigned W = TID_W + VLEN;

  logic                     clk, rst;
  logic [NUM_THREADS-1:0]   thread_en;
  logic [VLEN-1:0]          boot_addr;
  logic                     redirect_valid, miss_valid, refill_valid;
  logic [TID_W-1:0]         redirect_tid, miss_tid, refill_tid;
  logic [VLEN-1:0]          redirect_pc, miss_pc;
  logic                     fetch_valid, fetch_ready;
  logic [TID_W-1:0]         fetch_tid;
  logic [VLEN-1:0]          fetch_pc;
  logic [2*NUM_THREADS-1:0] thread_state;
  logic [PERF_W*NUM_THREADS-1:0] perf_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_item;

  thread_fetch_sel dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .thread_en_i      (thread_en),
    .boot_addr_i      (boot_addr),
    .redirect_valid_i (redirect_valid),
    .redirect_tid_i   (redirect_tid),
    .redirect_pc_i    (redirect_pc),
    .miss_valid_i     (miss_valid),
    .miss_tid_i       (miss_tid),
    .miss_pc_i        (miss_pc),
    .refill_valid_i   (refill_valid),
    .refill_tid_i     (refill_tid),
    .fetch_valid_o    (fetch_valid),
    .fetch_ready_i    (fetch_ready),
    .fetch_tid_o      (fetch_tid),
    .fetch_pc_o       (fetch_pc),
    .thread_state_o   (thread_state),
    .perf_fetch_cnt_o (perf_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic [TID_W-1:0] tid, input logic [VLEN-1:0] pc);
    chk({tag, "_valid"}, 64'(fetch_valid), 64'd1);
    chk({tag, "_tidpc"}, 64'({fetch_tid, fetch_pc}), 64'({tid, pc}));
  endtask

  // driver: reset with all side inputs quiet, then release with the given enable mask
  task automatic do_reset(input logic [NUM_THREADS-1:0] en, input logic [VLEN-1:0] boot);
    rst = 1'b1; thread_en = '0; boot_addr = boot; fetch_ready = 1'b1;
    redirect_valid = 1'b0; redirect_tid = '0; redirect_pc = '0;
    miss_valid = 1'b0; miss_tid = '0; miss_pc = '0;
    refill_valid = 1'b0; refill_tid = '0;
    tick();
    tick();
    rst = 1'b0;
    thread_en = en;
  endtask

  initial begin
    @(negedge clk);

    // 1: reset values, then all four threads in order 0,1,2,3,0
    do_reset(4'b0000, 32'h8000_0000);
    rst = 1'b1; thread_en = 4'b1111;
    tick();
    chk("rst_valid", 64'(fetch_valid), 64'd0);
    chk("rst_tid",   64'(fetch_tid),   64'd0);
    chk("rst_pc",    64'(fetch_pc),    64'd0);
    chk("rst_state", 64'(thread_state), 64'd0);
    chk("rst_perf",  64'(perf_cnt),    64'd0);
    rst = 1'b0;
    exp_q.push_back({2'd0, 32'h8000_0000});
    exp_q.push_back({2'd1, 32'h8000_0000});
    exp_q.push_back({2'd2, 32'h8000_0000});
    exp_q.push_back({2'd3, 32'h8000_0000});
    exp_q.push_back({2'd0, 32'h8000_0004});
    tick();
    chk("t1_state_run", 64'(thread_state), 64'h55);
    chk("t1_no_req_yet", 64'(fetch_valid), 64'd0);
    tick();
    while (exp_q.size() > 0) begin
      exp_item = exp_q.pop_front();
      chk("t1_valid", 64'(fetch_valid), 64'd1);
      chk("t1_rr", 64'({fetch_tid, fetch_pc}), 64'(exp_item));
      tick();
    end

    // 2: hold under back-pressure, then alternate 0,2
    do_reset(4'b0101, 32'h8000_0000);
    fetch_ready = 1'b0;
    tick(); tick();
    chk_fetch("t2_hold0", 2'd0, 32'h8000_0000);
    tick();
    chk_fetch("t2_hold1", 2'd0, 32'h8000_0000);
    tick();
    chk_fetch("t2_hold2", 2'd0, 32'h8000_0000);
    fetch_ready = 1'b1;
    tick();
    chk_fetch("t2_alt_a", 2'd2, 32'h8000_0000);
    tick();
    chk_fetch("t2_alt_b", 2'd0, 32'h8000_0004);
    tick();
    chk_fetch("t2_alt_c", 2'd2, 32'h8000_0004);

    // 3: miss parks tid1, refill resumes it at the replay PC
    do_reset(4'b1111, 32'h8000_0000);
    tick(); tick();
    chk_fetch("t3_first", 2'd0, 32'h8000_0000);
    miss_valid = 1'b1; miss_tid = 2'd1; miss_pc = 32'h0000_0100;
    tick();
    miss_valid = 1'b0;
    chk_fetch("t3_skip1", 2'd2, 32'h8000_0000);
    chk("t3_state1_miss", 64'(thread_state[3:2]), 64'(THR_MISS));
    tick();
    chk_fetch("t3_t3", 2'd3, 32'h8000_0000);
    tick();
    chk_fetch("t3_t0", 2'd0, 32'h8000_0004);
    tick();
    chk_fetch("t3_skip1_again", 2'd2, 32'h8000_0004);
    refill_valid = 1'b1; refill_tid = 2'd1;
    tick();
    refill_valid = 1'b0;
    chk_fetch("t3_after_refill", 2'd3, 32'h8000_0004);
    chk("t3_state1_run", 64'(thread_state[3:2]), 64'(THR_RUN));
    tick();
    chk_fetch("t3_t0b", 2'd0, 32'h8000_0008);
    tick();
    chk_fetch("t3_replay", 2'd1, 32'h0000_0100);

    // 4: redirect of the held thread kills the slot for one cycle
    do_reset(4'b0101, 32'h8000_0000);
    tick(); tick();
    chk_fetch("t4_first", 2'd0, 32'h8000_0000);
    tick();
    chk_fetch("t4_t2", 2'd2, 32'h8000_0000);
    fetch_ready = 1'b0;
    tick();
    chk_fetch("t4_t2_held", 2'd2, 32'h8000_0000);
    redirect_valid = 1'b1; redirect_tid = 2'd2; redirect_pc = 32'h0000_2000;
    tick();
    redirect_valid = 1'b0;
    chk("t4_killed", 64'(fetch_valid), 64'd0);
    tick();
    chk_fetch("t4_repick", 2'd0, 32'h8000_0004);
    fetch_ready = 1'b1;
    tick();
    chk_fetch("t4_refetch", 2'd2, 32'h0000_2000);

    // 5: PC wraps at the top of the space; redirect beats same-cycle accept
    do_reset(4'b0001, 32'hFFFF_FFFC);
    tick(); tick();
    chk_fetch("t5_top", 2'd0, 32'hFFFF_FFFC);
    tick();
    chk_fetch("t5_wrap", 2'd0, 32'h0000_0000);
    redirect_valid = 1'b1; redirect_tid = 2'd0; redirect_pc = 32'h0000_3000;
    tick();
    redirect_valid = 1'b0;
    chk_fetch("t5_redir_acc", 2'd0, 32'h0000_3000);
    tick();
    chk_fetch("t5_seq", 2'd0, 32'h0000_3004);

    // 6: ten accepts of tid3, then miss, disable with refill ignored
    do_reset(4'b1000, 32'h8000_0000);
    tick(); tick();
    for (int k = 0; k < 10; k++) begin
      chk_fetch("t6_seq", 2'd3, 32'h8000_0000 + 32'(4 * k));
      tick();
    end
`ifdef THREAD_FETCH_PERF_EN
    chk("t6_cnt3", 64'(perf_cnt[127:96]), 64'd10);
`else
    chk("t6_cnt3", 64'(perf_cnt[127:96]), 64'd0);
`endif
    chk("t6_cnt_others", 64'(perf_cnt[95:0]), 64'd0);
    fetch_ready = 1'b0;
    miss_valid = 1'b1; miss_tid = 2'd3; miss_pc = 32'h0000_0400;
    tick();
    miss_valid = 1'b0;
    chk("t6_miss_kill", 64'(fetch_valid), 64'd0);
    chk("t6_state3_miss", 64'(thread_state[7:6]), 64'(THR_MISS));
    thread_en = 4'b0000;
    refill_valid = 1'b1; refill_tid = 2'd3;
    tick();
    tick();
    refill_valid = 1'b0;
    chk("t6_state3_off", 64'(thread_state[7:6]), 64'(THR_OFF));
    chk("t6_idle", 64'(fetch_valid), 64'd0);
`ifdef THREAD_FETCH_PERF_EN
    chk("t6_cnt3_kept", 64'(perf_cnt[127:96]), 64'd10);
`else
    chk("t6_cnt3_kept", 64'(perf_cnt[127:96]), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
